// File: rtl/seg_scan_driver.sv
// Multiplexed multi-digit 7-segment driver (common anode, active-low segments and digit enables).
// Hex mode shows the value's nibbles. Decimal mode first runs a sequential shift-add-3
// binary-to-BCD conversion.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never
// blanked).
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned VALUE_W    = 16,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  dec_mode,
  input  logic                  load,
  output logic                  busy,
  output logic                  ovf,
  output logic [6:0]            s_segment,
  output logic [NUM_DIGITS-1:0] dig_n
);

  localparam int unsigned StoreW    = 4 * NUM_DIGITS;
  localparam int unsigned BcdDigits = (VALUE_W + 2) / 3 + 1;
  localparam int unsigned BcdW      = 4 * BcdDigits;
  localparam int unsigned HexExtW   = (VALUE_W > StoreW) ? VALUE_W : StoreW;
  localparam int unsigned BcdExtW   = (BcdW > StoreW) ? BcdW : StoreW;
  localparam int unsigned CntW      = $clog2(VALUE_W);
  localparam int unsigned PrescW    = $clog2(SCAN_DIV);
  localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BcdW-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [VALUE_W-1:0]  sh_q, sh_d;
  logic [StoreW-1:0]   store_q, store_d;
  logic                ovf_q, ovf_d;
  logic [PrescW-1:0]   presc_q;
  logic [IdxW-1:0]     idx_q;
  logic [6:0]          seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;
  logic [HexExtW-1:0]  val_ext;
  logic [BcdExtW-1:0]  bcd_ext;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic [NUM_DIGITS-1:0] blank;

  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign val_ext = HexExtW'(value);
  assign bcd_ext = BcdExtW'(bcd_q);

  // Add-3 correction of every BCD digit that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BcdDigits); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM next state; loads are accepted only in idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    sh_d    = sh_q;
    store_d = store_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          if (dec_mode) begin
            state_d = StConv;
            cnt_d   = '0;
            bcd_d   = '0;
            sh_d    = value;
          end else begin
            store_d = val_ext[StoreW-1:0];
            ovf_d   = |(val_ext >> StoreW);
          end
        end
      end
      StConv: begin
        bcd_d = (bcd_adj << 1) | BcdW'(sh_q[VALUE_W-1]);
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(VALUE_W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        store_d = bcd_ext[StoreW-1:0];
        ovf_d   = |(bcd_ext >> StoreW);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Conversion state and digit store registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bcd_q   <= '0;
      sh_q    <= '0;
      store_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      sh_q    <= sh_d;
      store_q <= store_d;
      ovf_q   <= ovf_d;
    end
  end

  // Scan prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PrescW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Leading-zero blanking mask: a digit blanks while it and all higher digits are zero.
  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
        zero_above = zero_above && (store_q[4*i +: 4] == 4'd0);
        blank[i]   = zero_above && (i != 0);
      end
    end
`endif
  end

  // Select the nibble of the currently strobed digit and decode it.
  always_comb begin
    cur_nib   = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (IdxW'(i) == idx_q) begin
        cur_nib   = store_q[4*i +: 4];
        cur_blank = blank[i];
      end
    end
    if (ovf_q) begin
      seg_d = SegDash;
    end else if (cur_blank) begin
      seg_d = SegBlank;
    end else begin
      seg_d = seg_lut(cur_nib);
    end
    dig_n_d = ~(NUM_DIGITS'(1) << idx_q);
  end

  // Segments and digit enable registered together so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= SegBlank;
      dig_n_q <= '1;
    end else begin
      seg_q   <= seg_d;
      dig_n_q <= dig_n_d;
    end
  end

  assign busy      = (state_q == StConv);
  assign ovf       = ovf_q;
  assign s_segment = seg_q;
  assign dig_n     = dig_n_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Multi-digit, time-multiplexed 7-segment display driver for the Led Game score and status display; the successor to the single-digit hex segment decoder. It latches a binary value and shows it on NUM_DIGITS common-anode digits. Hex mode shows nibbles directly. Decimal mode runs a sequential shift-add-3 binary-to-BCD conversion first. A prescaled scan counter strobes one digit at a time.

Parameters:
NUM_DIGITS, 4, number of display digits (1..8)
VALUE_W, 16, width of the input value (4..32)
SCAN_DIV, 50000, clock cycles each digit stays lit (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
value  input  VALUE_W  binary value to display
dec_mode  input  1  1 = decimal display, 0 = hex display; sampled with load
load  input  1  single-cycle strobe; capture value/dec_mode
busy  output  1  decimal conversion in progress
ovf  output  1  value does not fit in NUM_DIGITS digits
s_segment  output  7  active-low segments, bit order {g,f,e,d,c,b,a}
dig_n  output  NUM_DIGITS  active-low one-hot digit enable

Behaviour:
- Reset (async assert, sync release): s_segment=7'b1111111, dig_n all 1, busy=0, ovf=0, digit store=0, scan index=0, prescaler=0.
- Segment table for 0-F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110. Dash is 0111111 (g only).
- FSM states: IDLE, CONV, DONE.
- IDLE + load + !dec_mode:
  - Digit store gets value nibbles, zero-extended to 4*NUM_DIGITS, on the next edge (latency 1).
  - ovf = any value bit at or above 4*NUM_DIGITS is set.
  - busy stays 0.
- IDLE + load + dec_mode:
  - Go to CONV; busy=1 from the next cycle.
  - BCD register holds BCD_DIGITS = ceil(VALUE_W/3)+1 digits, cleared at entry.
  - Each CONV cycle: add 3 to every BCD digit >=5, then shift left one bit, taking in the shift-register MSB.
  - Exactly VALUE_W CONV cycles, then DONE.
- DONE (1 cycle):
  - Digit store gets the low NUM_DIGITS BCD digits.
  - ovf = any BCD digit at index >= NUM_DIGITS is nonzero.
  - busy=0; return to IDLE.
  - Total load-to-update latency is VALUE_W+2 cycles.
- load while busy=1 is ignored; the captured value and conversion are unaffected.
- The display keeps showing the previous digit store throughout CONV.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count, the scan index increments, wrapping NUM_DIGITS-1 to 0.
  - dig_n[i]=0 only for i == scan index.
  - s_segment and dig_n are both registered and change on the same edge; no glitch between them.
- ovf=1 overrides the display: every digit shows dash. ovf is updated only on the next accepted load.
- Scan begins on the first cycle after reset release. Digit store 0 shows "0" on every digit.
- rst_n asserted mid-CONV aborts the conversion; all state returns to reset values.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a digit shows blank (1111111) while it and every higher digit are zero. Digit 0 is never blanked. Blanking applies in both modes; ovf dashes take priority.
- Undefined: all digits always show their value; leading zeros are displayed.

Test Plan:
Bench parameters are NUM_DIGITS=4, VALUE_W=16, SCAN_DIV=4.
- Reset, then release -> s_segment=1111111, dig_n=1111 during reset; after release dig_n cycles 1110,1101,1011,0111 every 4 clocks, each digit showing 1000000.
- Hex load 16'hBEEF -> 1 cycle later, digit0=0001110 (F), digit1=0000110 (E), digit2=0000110, digit3=0000011 (B); busy never high; ovf=0.
- Decimal load 16'd1234 -> busy high exactly 16 cycles; digit store updates at cycle 18; digits0..3 show 0011001, 0110000, 0100100, 1111001.
- Decimal load 16'd12345 -> ovf=1 after conversion; all digits show 0111111. A following hex load 16'h0042 clears ovf.
- Second load (16'd9) 5 cycles into a 16'd1234 conversion -> ignored; result 1234. rst_n low at CONV cycle 8 -> busy=0, display shows 0.
- With LEADING_ZERO_BLANK_EN, decimal load 16'd7 -> digit0=1111000; digits1..3=1111111. Hex 16'h0000 -> digit0=1000000, others blank.
